pll_reset_sequencer: RTL and testbench
======================================

# pll_reset_sequencer

Reset and lock controller for the processor PLL. It runs on the 50 MHz reference clock and holds the PLL in reset after power-up. It releases the PLL, waits for a stable lock and only then releases the processor reset. On lock loss or a software relock request it re-sequences the PLL, and after repeated lock timeouts it raises a sticky failure flag.

## Interface
Parameters:
- RST_CYCLES, 16: refclk cycles `pll_rst` is held high on each entry to RESET_PLL (≥2).
- STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before release (≥1).
- LOCK_TIMEOUT, 65536: WAIT_LOCK cycles allowed before a retry (> STABLE_CYCLES).
- MAX_RETRIES, 4: lock timeouts tolerated before FAIL (≥1).

Ports (clock and reset first):
- `refclk`  in  1  reference clock; the block's only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `locked_i`  in  1  PLL `locked` output; asynchronous to `refclk`.
- `relock_req`  in  1  single-cycle pulse that forces a full re-sequence.
- `pll_rst`  out  1  drives the PLL `rst` input; active-high.
- `sys_rst_n`  out  1  processor reset request; active-low.
- `ready`  out  1  high in RUN only.
- `fail`  out  1  high in FAIL only.
- `state_o`  out  2  current state: 00 RESET_PLL, 01 WAIT_LOCK, 10 RUN, 11 FAIL.
- `loss_cnt`  out  8  count of lock-loss events; see Configuration.

## Operation
- `locked_i` passes through a 2-FF synchronizer to give `lock_s`. No other logic samples `locked_i`.
- All outputs are registered.
- Values while `rst_n` is low:
  - state = RESET_PLL, `pll_rst`=1, `sys_rst_n`=0, `ready`=0, `fail`=0, `loss_cnt`=0.
  - All counters are 0, including the synchronizer flops.
- RESET_PLL:
  - `pll_rst`=1, `sys_rst_n`=0.
  - The cycle counter runs from 0 to RST_CYCLES-1, then the block moves to WAIT_LOCK.
- WAIT_LOCK:
  - `pll_rst`=0, `sys_rst_n`=0.
  - The stable counter increments while `lock_s`=1 and clears to 0 whenever `lock_s`=0.
  - The stable counter reaching STABLE_CYCLES moves the block to RUN and clears the retry count.
  - The timeout counter increments every cycle. At LOCK_TIMEOUT, retries increments.
  - After a timeout, the block goes to FAIL if retries now equals MAX_RETRIES, otherwise to RESET_PLL.
  - If stable and timeout complete on the same cycle, the transition to RUN wins.
- RUN:
  - `sys_rst_n`=1, `ready`=1.
  - `lock_s`=0 moves the block to RESET_PLL and increments `loss_cnt`, which saturates at 255.
- FAIL:
  - `pll_rst`=1, `sys_rst_n`=0, `fail`=1.
  - The block stays in FAIL until `rst_n` goes low or `relock_req` arrives.
- `relock_req` in any state:
  - The next state is RESET_PLL, retries are cleared, and all counters restart.
  - `relock_req` has priority over every other transition.
  - Lock loss coincident with `relock_req` in RUN does not increment `loss_cnt`.
- Every state entry clears the cycle, stable and timeout counters.
- Counter widths are `$clog2` of their respective parameter plus 1. There is no wrap inside any state.

## Timing
- Synchronizer latency: 2 refclk edges from `locked_i` to `lock_s`.
- Output updates: state and outputs change on the refclk edge that performs the transition.
- RESET_PLL to WAIT_LOCK: `pll_rst` falls exactly RST_CYCLES edges after RESET_PLL entry, or after `rst_n` release.
- WAIT_LOCK to RUN, with `locked_i` steady high: `ready` and `sys_rst_n` rise STABLE_CYCLES edges after the first edge on which `lock_s`=1.
- Lock loss in RUN: `sys_rst_n` falls 3 edges after `locked_i` falls (2 synchronizer edges plus 1 state edge). `pll_rst` rises on the same edge.
- `relock_req`: `pll_rst`=1 and `sys_rst_n`=0 on the edge following the pulse.
- Reset: assertion of `rst_n` mid-sequence forces the reset values immediately (asynchronously). Release is synchronous to the next `refclk` edge.
- Glitches: a `locked_i` glitch shorter than one refclk period may or may not be seen. Any `lock_s`=0 cycle in WAIT_LOCK restarts the stable count.

## Configuration
- Macro: `PLL_SEQ_LOSS_CNT_EN`.
- Defined: the 8-bit saturating `loss_cnt` register exists and behaves as described above.
- Undefined: the register is not built, `loss_cnt` is tied to 8'h00, and all other behaviour is identical.

## Test plan
Bench parameters: RST_CYCLES=4, STABLE_CYCLES=8, LOCK_TIMEOUT=32, MAX_RETRIES=2.
- Power-up: release `rst_n` with `locked_i`=0 → `pll_rst`=1 for 4 edges, then 0, `state_o`=01. Raise `locked_i` → `ready`=1 and `sys_rst_n`=1 10 edges later (2+8).
- Lock chatter: in WAIT_LOCK, drop `locked_i` for 1 cycle after 5 stable cycles → stable count restarts, and `ready` rises 8 edges after `lock_s` returns.
- Lock loss: drop `locked_i` in RUN → 3 edges later `sys_rst_n`=0, `pll_rst`=1, `state_o`=00, `loss_cnt`=1. Repeat 300 times → `loss_cnt`=255.
- Timeout to FAIL: hold `locked_i`=0 → two 32-cycle timeouts, then `state_o`=11, `fail`=1, `pll_rst`=1. Pulse `relock_req` → `state_o`=00 and `fail`=0 next edge.
- Simultaneous events: in RUN, pulse `relock_req` on the same edge `lock_s` falls → RESET_PLL, `loss_cnt` unchanged. Assert `rst_n` low mid-WAIT_LOCK → all outputs at reset values immediately.
- Macro off: rerun the lock-loss test → `loss_cnt` stays 8'h00, and all other responses are identical.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer on the reference clock: PLL reset, lock qualification, run, retry and failure.
// Optional PLL_SEQ_LOSS_CNT_EN builds the saturating lock-loss counter; otherwise loss_cnt is 8'h00.
//
// state     | meaning
// ----------+------------------------------------------------------------
// RESET_PLL | PLL held in reset for RST_CYCLES cycles
// WAIT_LOCK | PLL released, qualifying lock, bounded by LOCK_TIMEOUT
// RUN       | lock qualified, processor reset released
// FAIL      | MAX_RETRIES lock timeouts, PLL held in reset until relock_req
module pll_reset_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int STABLE_CYCLES = 1024,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int MAX_RETRIES   = 4
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       locked_i,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fail,
    output logic [1:0] state_o,
    output logic [7:0] loss_cnt
);
    localparam int CW = $clog2(RST_CYCLES) + 1;
    localparam int SW = $clog2(STABLE_CYCLES) + 1;
    localparam int TW = $clog2(LOCK_TIMEOUT) + 1;
    localparam int QW = $clog2(MAX_RETRIES) + 1;

    localparam logic [CW-1:0] CYC_LAST  = CW'(RST_CYCLES - 1);
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(LOCK_TIMEOUT - 1);
    localparam logic [QW-1:0] RETRY_MAX = QW'(MAX_RETRIES);

    typedef enum logic [1:0] {
        RESET_PLL = 2'b00,
        WAIT_LOCK = 2'b01,
        RUN       = 2'b10,
        FAIL      = 2'b11
    } state_t;

    state_t          state, state_nx;
    logic            sync1, lock_s;
    logic [CW-1:0]   cyc, cyc_nx;
    logic [SW-1:0]   stab, stab_nx;
    logic [TW-1:0]   tmo, tmo_nx;
    logic [QW-1:0]   retry, retry_nx, retry_inc;

    assign retry_inc = retry + 1'b1;
    assign state_o   = state;

    // locked_i is asynchronous; only lock_s is used downstream
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            sync1  <= locked_i;
            lock_s <= sync1;
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RESET_PLL;
            cyc   <= '0;
            stab  <= '0;
            tmo   <= '0;
            retry <= '0;
        end else begin
            state <= state_nx;
            cyc   <= cyc_nx;
            stab  <= stab_nx;
            tmo   <= tmo_nx;
            retry <= retry_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cyc_nx   = cyc;
        stab_nx  = stab;
        tmo_nx   = tmo;
        retry_nx = retry;
        case (state)
            RESET_PLL: begin
                if (cyc == CYC_LAST) state_nx = WAIT_LOCK;
                else                 cyc_nx   = cyc + 1'b1;
            end
            WAIT_LOCK: begin
                stab_nx = lock_s ? stab + 1'b1 : '0;
                tmo_nx  = tmo + 1'b1;
                // a qualified lock beats a coincident timeout
                if (lock_s && (stab == STAB_LAST)) begin
                    state_nx = RUN;
                    retry_nx = '0;
                end else if (tmo == TMO_LAST) begin
                    retry_nx = retry_inc;
                    state_nx = (retry_inc == RETRY_MAX) ? FAIL : RESET_PLL;
                end
            end
            RUN: begin
                if (!lock_s) state_nx = RESET_PLL;
            end
            FAIL: begin
                state_nx = FAIL;
            end
            default: state_nx = RESET_PLL;
        endcase
        if (relock_req) begin
            state_nx = RESET_PLL;
            retry_nx = '0;
        end
        if ((state_nx != state) || relock_req) begin
            cyc_nx  = '0;
            stab_nx = '0;
            tmo_nx  = '0;
        end
    end

    // outputs registered from the next state so they move on the transition edge
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
            fail      <= 1'b0;
        end else begin
            pll_rst   <= (state_nx == RESET_PLL) || (state_nx == FAIL);
            sys_rst_n <= (state_nx == RUN);
            ready     <= (state_nx == RUN);
            fail      <= (state_nx == FAIL);
        end
    end

`ifdef PLL_SEQ_LOSS_CNT_EN
    logic [7:0] loss_q;
    logic       loss_inc;

    assign loss_inc = (state == RUN) && !lock_s && !relock_req;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n)                              loss_q <= 8'h00;
        else if (loss_inc && (loss_q != 8'hFF))  loss_q <= loss_q + 8'h01;
    end

    assign loss_cnt = loss_q;
`else
    assign loss_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed and randomized bench for pll_reset_sequencer against a timestamp-based reference model.
// Expected loss_cnt follows PLL_SEQ_LOSS_CNT_EN in the same way as the design.
module tb_pll_reset_sequencer;
    localparam int RST  = 4;
    localparam int STAB = 8;
    localparam int TMO  = 32;
    localparam int MAXR = 2;

    localparam int S_RESET = 0;
    localparam int S_WAIT  = 1;
    localparam int S_RUN   = 2;
    localparam int S_FAIL  = 3;

    logic       refclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       locked_i = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst, sys_rst_n, ready, fail;
    logic [1:0] state_o;
    logic [7:0] loss_cnt;

    int vectors = 0;
    int miscompares = 0;

    // reference model: edge counter, entry timestamp, last lock-low timestamp
    int n, m_state, m_entry, m_zero, m_retry, m_loss;
    bit hist[$];

    pll_reset_sequencer #(
        .RST_CYCLES(RST), .STABLE_CYCLES(STAB), .LOCK_TIMEOUT(TMO), .MAX_RETRIES(MAXR)
    ) dut (
        .refclk(refclk), .rst_n(rst_n), .locked_i(locked_i), .relock_req(relock_req),
        .pll_rst(pll_rst), .sys_rst_n(sys_rst_n), .ready(ready), .fail(fail),
        .state_o(state_o), .loss_cnt(loss_cnt)
    );

    always #5 refclk = ~refclk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        n = 0; m_state = S_RESET; m_entry = 0; m_zero = 0; m_retry = 0; m_loss = 0;
        hist.delete();
    endtask

    function automatic logic [7:0] exp_loss();
`ifdef PLL_SEQ_LOSS_CNT_EN
        return 8'(m_loss);
`else
        return 8'h00;
`endif
    endfunction

    task automatic model_step(input bit ls, input bit rq);
        int k = n - m_entry;
        int nxt = m_state;
        case (m_state)
            S_RESET: if (k >= RST) nxt = S_WAIT;
            S_WAIT: begin
                if (ls && (n - m_zero) >= STAB) begin
                    nxt = S_RUN;
                    m_retry = 0;
                end else if (k >= TMO) begin
                    m_retry++;
                    nxt = (m_retry >= MAXR) ? S_FAIL : S_RESET;
                end
                if (!ls) m_zero = n;
            end
            S_RUN: if (!ls) begin
                nxt = S_RESET;
                if (!rq && m_loss < 255) m_loss++;
            end
            default: nxt = m_state;
        endcase
        if (rq) begin
            nxt = S_RESET;
            m_retry = 0;
        end
        if (nxt != m_state || rq) begin
            m_entry = n;
            m_zero = n;
        end
        m_state = nxt;
    endtask

    task automatic check_all();
        chk("state_o", 8'(state_o), 8'(m_state));
        chk("pll_rst", 8'(pll_rst), 8'(m_state == S_RESET || m_state == S_FAIL));
        chk("sys_rst_n", 8'(sys_rst_n), 8'(m_state == S_RUN));
        chk("ready", 8'(ready), 8'(m_state == S_RUN));
        chk("fail", 8'(fail), 8'(m_state == S_FAIL));
        chk("loss_cnt", loss_cnt, exp_loss());
    endtask

    // one refclk edge: the DUT samples the inputs currently driven; lock_s lags locked_i by two edges
    task automatic tick();
        bit ls;
        @(posedge refclk);
        #1;
        n++;
        ls = (hist.size() >= 2) ? hist[hist.size()-2] : 1'b0;
        hist.push_back(locked_i);
        if (hist.size() > 3) void'(hist.pop_front());
        model_step(ls, relock_req);
        check_all();
    endtask

    task automatic pulse_relock();
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
    endtask

    task automatic run_to(input int target);
        int g = 0;
        while (m_state != target && g < 300) begin
            if (m_state == S_FAIL && target != S_FAIL) pulse_relock();
            else tick();
            g++;
        end
        chk("reach_state", 8'(state_o), 8'(target));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_state"}, 8'(state_o), 8'd0);
        chk({tag, "_pll_rst"}, 8'(pll_rst), 8'd1);
        chk({tag, "_sys_rst_n"}, 8'(sys_rst_n), 8'd0);
        chk({tag, "_ready"}, 8'(ready), 8'd0);
        chk({tag, "_fail"}, 8'(fail), 8'd0);
        chk({tag, "_loss"}, loss_cnt, 8'd0);
    endtask

    initial begin
        int cnt;
        logic [7:0] saved_loss;

        model_reset();
        repeat (3) @(posedge refclk);
        #1;
        check_reset_values("por");

        // power-up: PLL reset for RST edges, then lock qualification 2+STAB edges after locked_i rises
        rst_n = 1'b1;
        repeat (RST - 1) begin
            tick();
            chk("pwrup_pll_rst_held", 8'(pll_rst), 8'd1);
        end
        tick();
        chk("pwrup_pll_rst_fall", 8'(pll_rst), 8'd0);
        chk("pwrup_wait_lock", 8'(state_o), 8'd1);
        locked_i = 1'b1;
        repeat (2 + STAB - 1) tick();
        chk("pwrup_ready_early", 8'(ready), 8'd0);
        tick();
        chk("pwrup_ready", 8'(ready), 8'd1);
        chk("pwrup_sys_rst_n", 8'(sys_rst_n), 8'd1);

        // lock chatter: one low sample after five stable cycles restarts qualification
        locked_i = 1'b0;
        pulse_relock();
        run_to(S_WAIT);
        locked_i = 1'b1;
        repeat (7) tick();
        locked_i = 1'b0;
        tick();
        locked_i = 1'b1;
        repeat (9) tick();
        chk("chatter_still_waiting", 8'(state_o), 8'd1);
        tick();
        chk("chatter_ready", 8'(ready), 8'd1);

        // repeated lock loss with random dwell; loss count saturates
        for (int i = 0; i < 300; i++) begin
            locked_i = 1'b0;
            tick();
            tick();
            chk("loss_still_run", 8'(sys_rst_n), 8'd1);
            tick();
            chk("loss_sys_rst_n", 8'(sys_rst_n), 8'd0);
            chk("loss_pll_rst", 8'(pll_rst), 8'd1);
            chk("loss_state", 8'(state_o), 8'd0);
            repeat ($urandom_range(0, 5)) tick();
            locked_i = 1'b1;
            run_to(S_RUN);
        end
        chk("loss_saturated", loss_cnt, exp_loss());

        // timeout to FAIL: RST + TMO + RST + TMO edges after relock
        locked_i = 1'b0;
        pulse_relock();
        cnt = 0;
        while (fail !== 1'b1 && cnt < 200) begin
            tick();
            cnt++;
        end
        chk("fail_latency", 8'(cnt), 8'(2 * (RST + TMO)));
        chk("fail_state", 8'(state_o), 8'd3);
        chk("fail_pll_rst", 8'(pll_rst), 8'd1);
        locked_i = 1'b1;
        repeat ($urandom_range(5, 20)) tick();
        chk("fail_sticky", 8'(fail), 8'd1);
        pulse_relock();
        chk("relock_state", 8'(state_o), 8'd0);
        chk("relock_fail_clr", 8'(fail), 8'd0);

        // relock_req coincident with lock_s falling in RUN
        run_to(S_RUN);
        saved_loss = loss_cnt;
        locked_i = 1'b0;
        tick();
        tick();
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        chk("simul_state", 8'(state_o), 8'd0);
        chk("simul_loss", loss_cnt, saved_loss);

        // randomized lock activity and occasional relock pulses
        for (int i = 0; i < 2000; i++) begin
            locked_i   = ($urandom_range(0, 19) < 18);
            relock_req = ($urandom_range(0, 79) == 0);
            tick();
            relock_req = 1'b0;
        end

        // asynchronous reset mid-WAIT_LOCK
        locked_i = 1'b0;
        pulse_relock();
        run_to(S_WAIT);
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        model_reset();
        repeat (2) @(posedge refclk);
        #1;
        rst_n = 1'b1;
        locked_i = 1'b1;
        run_to(S_RUN);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
